// File: rtl/gba_mmio_defines.sv
// gba_mmio_defines: shared MMIO constants and types
// for the direct-sound DMA channels.
package gba_mmio_defines;

  localparam logic [31:0] FIFO_A_ADDR = 32'h040000A0;
  localparam logic [31:0] FIFO_B_ADDR = 32'h040000A4;

  localparam logic [1:0] SRC_INC     = 2'b00;
  localparam logic [1:0] SRC_DEC     = 2'b01;
  localparam logic [1:0] SRC_FIX     = 2'b10;
  localparam logic [1:0] SRC_INC_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } dma_state_e;

  function automatic logic [31:0] next_src(
    input logic [31:0] a,
    input logic [1:0]  ctl
  );
    logic [31:0] r;
    unique case (ctl)
      SRC_DEC:              r = a - 32'd4;
      SRC_FIX:              r = a;
      SRC_INC, SRC_INC_ALT: r = a + 32'd4;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gba_sound_fifo_dma_if.sv
// gba_sound_fifo_dma_if: single-beat bus between the
// sound DMA channel (master) and the DMA arbiter.
interface gba_sound_fifo_dma_if;

  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_valid,
    output bus_write,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ready
  );

  modport slave (
    input  bus_valid,
    input  bus_write,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ready
  );

endinterface

// File: rtl/gba_sound_fifo_dma.sv
// gba_sound_fifo_dma: direct-sound DMA channel moving
// WORDS_PER_BURST words into a sound FIFO per request.
module gba_sound_fifo_dma
  import gba_mmio_defines::*;
#(
  parameter logic [31:0] FIFO_ADDR       = FIFO_A_ADDR,
  parameter int          WORDS_PER_BURST = 4
) (
  input  logic                 gba_clk,
  input  logic                 reset,
  input  logic                 sound_req,
  input  logic                 dma_enable,
  input  logic                 dma_repeat,
  input  logic [1:0]           src_ctl,
  input  logic [31:0]          src_addr_init,
  input  logic                 irq_en,
  gba_sound_fifo_dma_if.master bus,
  output logic                 busy,
  output logic                 irq,
  output logic                 enable_clear
);

  localparam int CW =
    (WORDS_PER_BURST > 1) ? $clog2(WORDS_PER_BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BURST - 1);

  dma_state_e    r_state;
  dma_state_e    w_next;
  logic          r_pend;
  logic          r_req_q;
  logic          r_en_q;
  logic          r_abort;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_src;
  logic [31:0]   r_data;

  logic          w_hs;
  logic          w_req_rise;
  logic          w_en_rise;
  logic          w_start;
  logic          w_stop;
  logic          w_last;
  logic          w_valid;
  logic          w_write;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;

  assign w_hs       = w_valid & bus.bus_ready;
  assign w_req_rise = sound_req & ~r_req_q;
  assign w_en_rise  = dma_enable & ~r_en_q;
  assign w_start    = (sound_req | r_pend) & dma_enable;
  // An enable drop is remembered so a later re-raise
  // cannot resurrect the burst before the beat ends.
  assign w_stop     = r_abort | ~dma_enable;
  assign w_last     = (r_cnt == LAST);

  assign bus.bus_valid = w_valid;
  assign bus.bus_write = w_write;
  assign bus.bus_addr  = w_addr;
  assign bus.bus_wdata = w_wdata;

  // State register.
  always_ff @(posedge gba_clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and bus/pulse outputs.
  always_comb begin
    w_next       = r_state;
    w_valid      = 1'b0;
    w_write      = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    irq          = 1'b0;
    enable_clear = 1'b0;
    busy         = (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_RD;
      end
      ST_RD: begin
        w_valid = 1'b1;
        w_addr  = r_src;
        if (w_hs) w_next = w_stop ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        w_valid = 1'b1;
        w_write = 1'b1;
        w_addr  = FIFO_ADDR;
        w_wdata = r_data;
        if (w_hs) begin
          if (w_stop)      w_next = ST_IDLE;
          else if (w_last) w_next = ST_DONE;
          else             w_next = ST_RD;
        end
      end
      ST_DONE: begin
        irq          = irq_en;
        enable_clear = ~dma_repeat;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Source pointer, data, word count and pending request.
  always_ff @(posedge gba_clk or negedge reset) begin
    if (!reset) begin
      r_pend  <= 1'b0;
      r_req_q <= 1'b0;
      r_en_q  <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
      r_src   <= '0;
      r_data  <= '0;
    end else begin
      r_req_q <= sound_req;
      r_en_q  <= dma_enable;
      if (r_state != ST_IDLE && w_req_rise && dma_enable)
        r_pend <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          r_abort <= 1'b0;
          if (w_en_rise) begin
            r_src <= src_addr_init & ~32'h3;
            r_cnt <= '0;
          end
          if (w_start) r_pend <= 1'b0;
        end
        ST_RD: begin
          if (!dma_enable) r_abort <= 1'b1;
          if (w_hs) begin
            r_data <= bus.bus_rdata;
            if (w_stop) begin
              r_abort <= 1'b0;
              r_pend  <= 1'b0;
              r_cnt   <= '0;
            end
          end
        end
        ST_WR: begin
          if (!dma_enable) r_abort <= 1'b1;
          if (w_hs) begin
            r_src <= next_src(r_src, src_ctl);
            r_cnt <= r_cnt + CW'(1);
            if (w_stop) begin
              r_abort <= 1'b0;
              r_pend  <= 1'b0;
              r_cnt   <= '0;
            end
          end
        end
        ST_DONE: r_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gba_sound_fifo_dma.md
GBA_SOUND_FIFO_DMA -- requirements
Module: gba_sound_fifo_dma

Interface
REQ-001 Parameter FIFO_ADDR, default 32'h040000A0, is the fixed destination address (FIFO_A; set 32'h040000A4 for FIFO_B).
REQ-002 Parameter WORDS_PER_BURST, default 4, is the number of 32-bit words moved per sound request.
REQ-003 gba_clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sound_req  input  1  request from the direct-sound channel; level, sampled each cycle.
REQ-006 dma_enable  input  1  DMA channel enable (DMAxCNT_H[15], start timing = special).
REQ-007 dma_repeat  input  1  repeat bit; 0 means clear the enable after one burst.
REQ-008 src_ctl  input  2  source address control: 00 increment, 01 decrement, 10 fixed, 11 treated as increment.
REQ-009 src_addr_init  input  32  source address, loaded on the rising edge of dma_enable.
REQ-010 irq_en  input  1  raise an interrupt at burst end.
REQ-011 bus_valid  output  1  bus beat request.
REQ-012 bus_write  output  1  1 = write beat, 0 = read beat.
REQ-013 bus_addr  output  32  beat address.
REQ-014 bus_wdata  output  32  write data.
REQ-015 bus_rdata  input  32  read data, valid while bus_ready=1 on a read beat.
REQ-016 bus_ready  input  1  beat completes on any cycle where bus_valid and bus_ready are both 1.
REQ-017 busy  output  1  1 whenever the state is not IDLE.
REQ-018 irq  output  1  one-cycle pulse at burst end when irq_en=1.
REQ-019 enable_clear  output  1  one-cycle pulse at burst end when dma_repeat=0; the register block clears dma_enable on this pulse.

Function
REQ-020 States are IDLE, RD, WR and DONE.
REQ-021 IDLE -> RD when (sound_req or pend) and dma_enable; pend is cleared on this transition.
REQ-022 RD: bus_valid=1, bus_write=0, bus_addr=cur_src; on handshake, capture bus_rdata into a data register and go to WR.
REQ-023 WR: bus_valid=1, bus_write=1, bus_addr=FIFO_ADDR, bus_wdata=data register; on handshake, update cur_src and increment the word counter.
REQ-024 WR completion goes to DONE when word counter = WORDS_PER_BURST-1; otherwise it goes to RD.
REQ-025 cur_src update per word: increment +4, decrement -4, fixed unchanged; 32-bit wrap-around with no saturation.
REQ-026 Address alignment: cur_src[1:0] is forced to 00 at load.
REQ-027 DONE lasts one cycle: irq=irq_en, enable_clear=~dma_repeat, word counter cleared, then IDLE.
REQ-028 bus_valid, bus_addr, bus_write and bus_wdata remain stable from assertion until handshake; bus_valid never drops without a handshake.
REQ-029 Minimum latency: sound_req high in IDLE gives bus_valid=1 on the next cycle; with bus_ready tied high, a burst takes 2*WORDS_PER_BURST+1 cycles from leaving IDLE to returning to IDLE.
REQ-030 A sound_req rising edge while not in IDLE sets pend (one-deep); further requests while pend=1 are dropped.
REQ-031 dma_enable falling mid-burst: the outstanding beat completes, then the state machine goes to IDLE with no irq, no enable_clear and pend cleared; cur_src keeps its value.
REQ-032 dma_enable rising while busy does not reload cur_src; the reload occurs only when the rising edge is seen in IDLE.
REQ-033 sound_req while dma_enable=0 is ignored and not recorded in pend.
REQ-034 Simultaneous DONE and new sound_req rising edge: the request is recorded in pend and serviced from IDLE on the following cycle, if still enabled.

Reset
REQ-035 While reset=0: state=IDLE and pend=0.
REQ-036 While reset=0: counter=0, cur_src=0 and data register=0.
REQ-037 While reset=0: bus_valid=0, bus_write=0, bus_addr=0, bus_wdata=0, busy=0, irq=0 and enable_clear=0.
REQ-038 Reset assertion mid-burst abandons the beat immediately; no completion pulses are produced.

Structure
REQ-039 The state enum, src_ctl encodings and the FIFO_A/FIFO_B address constants live in the shared gba_mmio_defines package/header.
REQ-040 The block has no sub-modules; audio top instantiates two copies (FIFO_A, FIFO_B) driven by sound_req1/sound_req2, sharing the bus through the existing DMA arbiter.

Verification
REQ-041 Directed test, basic burst: src_addr_init=32'h02000000, inc, bus_ready=1, one sound_req -> reads at 02000000/04/08/0C, each followed by a write of the same data to 040000A0; irq pulses once (irq_en=1); burst takes 9 cycles.
REQ-042 Directed test, decrement and fixed: src_ctl=01 from 32'h02000010 -> reads at 10/0C/08/04; src_ctl=10 -> all four reads at 02000010.
REQ-043 Directed test, back-pressure: bus_ready low for 3 cycles on each beat -> bus signals stay stable while stalled, data is correct and the order is unchanged.
REQ-044 Directed test, pending request: second sound_req edge during word 2 -> a second burst starts 1 cycle after the first DONE, from src+16; a third edge in the same window is dropped.
REQ-045 Directed test, non-repeat and abort: dma_repeat=0 -> enable_clear pulses in DONE; dma_enable dropped during the second WR -> that write completes, the block returns to IDLE, and neither irq nor enable_clear pulses.
REQ-046 Directed test, address wrap: src_addr_init=32'hFFFFFFF8, inc -> reads at FFFFFFF8, FFFFFFFC, 00000000, 00000004.
